// File: rtl/mcs4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcs4_pkg
// Description : Shared MCS-4 timing constants: phase indices, quarter-phase
//               slot indices and the clock generator run/halt state encoding.
//               The phase constants are also used by timing_recovery.
// Revision    : 1.0 - initial release
// ============================================================================
package mcs4_pkg;

    // Instruction-cycle phases, in bus order
    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    // Quarter-phase slots: clk1 and clk2 are separated by a gap on each side
    localparam logic [1:0] SL_CLK1 = 2'd0;
    localparam logic [1:0] SL_GAP1 = 2'd1;
    localparam logic [1:0] SL_CLK2 = 2'd2;
    localparam logic [1:0] SL_GAP2 = 2'd3;

    // Generator state
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

endpackage : mcs4_pkg
`default_nettype wire

// File: rtl/mcs4_poc_timer.sv
`default_nettype none
// ============================================================================
// Module      : mcs4_poc_timer
// Description : Power-on-clear hold timer. Counts complete instruction cycles
//               after reset or a poc_req and drops poc at the end of the
//               final X3. A request always reloads the full count.
// Revision    : 1.0 - initial release
// ============================================================================
module mcs4_poc_timer #(
    parameter int POC_CYCLES = 16
) (
    input  logic sysclk,
    input  logic sysrst_n,
    input  logic poc_req,
    input  logic cyc_end,
    output logic poc
);

    localparam int                    c_LEFT_W    = $clog2(POC_CYCLES + 1);
    localparam logic [c_LEFT_W-1:0]   c_LEFT_LOAD = c_LEFT_W'(POC_CYCLES);
    localparam logic [c_LEFT_W-1:0]   c_LEFT_ONE  = c_LEFT_W'(1);

    logic [c_LEFT_W-1:0] r_poc_left;
    logic                r_poc;

    // Reload on request (wins over a same-edge decrement), else count cycle ends
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_poc_left <= c_LEFT_LOAD;
            r_poc      <= 1'b1;
        end else if (poc_req) begin
            r_poc_left <= c_LEFT_LOAD;
            r_poc      <= 1'b1;
        end else if (cyc_end && (r_poc_left != '0)) begin
            r_poc_left <= r_poc_left - c_LEFT_ONE;
            if (r_poc_left == c_LEFT_ONE) begin
                r_poc <= 1'b0;
            end
        end
    end

    assign poc = r_poc;

endmodule : mcs4_poc_timer
`default_nettype wire

// File: rtl/mcs4_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : mcs4_clkgen
// Description : MCS-4 two-phase clock, SYNC and POC generator with run/halt/
//               single-step control that only ever stops the bus on an
//               instruction-cycle boundary. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mcs4_clkgen
    import mcs4_pkg::*;
#(
    parameter int SLOT_LEN   = 8,
    parameter int POC_CYCLES = 16
) (
    input  logic       sysclk,
    input  logic       sysrst_n,
    input  logic       run,
    input  logic       step,
    input  logic       poc_req,
    output logic       clk1,
    output logic       clk2,
    output logic       sync,
    output logic       poc,
    output logic [2:0] phase,
    output logic       phase_start,
    output logic       halted
);

    localparam int                  c_CNT_W    = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(SLOT_LEN - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);

    // Position registers hold the slot currently shown on the outputs
    logic [0:0]         r_state;
    logic               r_live;
    logic [c_CNT_W-1:0] r_slot_cnt;
    logic [1:0]         r_slot;
    logic [2:0]         r_phase;

    logic               r_clk1;
    logic               r_clk2;
    logic               r_sync;
    logic               r_phase_start;
    logic               r_halted;

    logic [0:0]         w_state_nxt;
    logic               w_live_nxt;
    logic [c_CNT_W-1:0] w_slot_cnt_nxt;
    logic [1:0]         w_slot_nxt;
    logic [2:0]         w_phase_nxt;

    logic               w_clk1_nxt;
    logic               w_clk2_nxt;
    logic               w_sync_nxt;
    logic               w_phase_start_nxt;
    logic               w_halted_nxt;

    logic               w_advance;
    logic               w_cyc_end;
    logic               w_poc;

    // r_live is clear right after reset and while parked: the parked position
    // (A1/slot 0/0) has not been shown yet, so the first running edge shows
    // it instead of stepping past it.
    assign w_advance = (r_state == ST_RUN) && r_live;
    assign w_cyc_end = w_advance && (r_phase == PH_X3) &&
                       (r_slot == SL_GAP2) && (r_slot_cnt == c_CNT_LAST);

    mcs4_poc_timer #(
        .POC_CYCLES (POC_CYCLES)
    ) u_poc_timer (
        .sysclk   (sysclk),
        .sysrst_n (sysrst_n),
        .poc_req  (poc_req),
        .cyc_end  (w_cyc_end),
        .poc      (w_poc)
    );

    // State, position counters and registered outputs
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            r_state       <= ST_RUN;
            r_live        <= 1'b0;
            r_slot_cnt    <= '0;
            r_slot        <= SL_CLK1;
            r_phase       <= PH_A1;
            r_clk1        <= 1'b0;
            r_clk2        <= 1'b0;
            r_sync        <= 1'b0;
            r_phase_start <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_live        <= w_live_nxt;
            r_slot_cnt    <= w_slot_cnt_nxt;
            r_slot        <= w_slot_nxt;
            r_phase       <= w_phase_nxt;
            r_clk1        <= w_clk1_nxt;
            r_clk2        <= w_clk2_nxt;
            r_sync        <= w_sync_nxt;
            r_phase_start <= w_phase_start_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    // Next state and next position; a cycle-end wrap also parks at A1/slot 0/0
    always_comb begin
        w_state_nxt    = r_state;
        w_slot_cnt_nxt = r_slot_cnt;
        w_slot_nxt     = r_slot;
        w_phase_nxt    = r_phase;

        case (r_state)
            ST_RUN: begin
                if (w_cyc_end && !run && !w_poc) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                // step together with run is simply a resume
                if (run || step || poc_req || w_poc) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        if (w_advance) begin
            if (r_slot_cnt == c_CNT_LAST) begin
                w_slot_cnt_nxt = '0;
                if (r_slot == SL_GAP2) begin
                    w_slot_nxt  = SL_CLK1;
                    w_phase_nxt = r_phase + 3'd1;
                end else begin
                    w_slot_nxt  = r_slot + 2'd1;
                end
            end else begin
                w_slot_cnt_nxt = r_slot_cnt + c_CNT_ONE;
            end
        end

        w_live_nxt = (w_state_nxt == ST_RUN);
    end

    // Decode the upcoming position into the values registered on this edge
    always_comb begin
        w_clk1_nxt        = 1'b0;
        w_clk2_nxt        = 1'b0;
        w_sync_nxt        = 1'b0;
        w_phase_start_nxt = 1'b0;
        w_halted_nxt      = 1'b0;

        if (w_state_nxt == ST_HALT) begin
            w_halted_nxt = 1'b1;
        end else begin
            w_clk1_nxt        = (w_slot_nxt == SL_CLK1);
            w_clk2_nxt        = (w_slot_nxt == SL_CLK2);
            w_sync_nxt        = (w_phase_nxt == PH_X3);
            w_phase_start_nxt = (w_slot_nxt == SL_CLK1) && (w_slot_cnt_nxt == '0);
        end
    end

    assign clk1        = r_clk1;
    assign clk2        = r_clk2;
    assign sync        = r_sync;
    assign poc         = w_poc;
    assign phase       = r_phase;
    assign phase_start = r_phase_start;
    assign halted      = r_halted;

endmodule : mcs4_clkgen
`default_nettype wire
